// File: rtl/fetch_pkg.sv
// Shared types and constants for the two-word instruction fetch unit.
// The optional opcode trap is built only when FETCH_ILLEGAL_TRAP_EN is defined.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        W0    = 3'd1,
        W1    = 3'd2,
        ISSUE = 3'd3,
        HOLD  = 3'd4
    } fetch_state_t;

    // Field positions inside the first ROM word of an instruction
    localparam int EXE_HI  = 15;
    localparam int EXE_LO  = 11;
    localparam int REG1_HI = 10;
    localparam int REG1_LO = 9;
    localparam int REG2_HI = 8;
    localparam int REG2_LO = 7;

    localparam int OP_W    = EXE_HI - EXE_LO + 1;
    localparam int REG_W   = REG1_HI - REG1_LO + 1;
    localparam int EDATA_W = 16;

    localparam logic [OP_W-1:0] ILLEGAL_OP_MIN = 5'd28;

    function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
        return op >= ILLEGAL_OP_MIN;
    endfunction

endpackage

// File: rtl/fetch_decode.sv
// Combinational split of the first instruction word into opcode and register fields.
// With FETCH_ILLEGAL_TRAP_EN, reserved opcodes become a NOP and raise illegal.
module fetch_decode
    import fetch_pkg::*;
(
    input  logic [EXE_HI:REG2_LO] hdr,
    output logic [OP_W-1:0]       exe,
    output logic [REG_W-1:0]      ereg1,
    output logic [REG_W-1:0]      ereg2,
    output logic                  illegal
);

    always_comb begin
        exe     = hdr[EXE_HI:EXE_LO];
        ereg1   = hdr[REG1_HI:REG1_LO];
        ereg2   = hdr[REG2_HI:REG2_LO];
        illegal = 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
        if (is_illegal_op(hdr[EXE_HI:EXE_LO])) begin
            exe     = '0;
            illegal = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/instr_fetch.sv
// Two-word instruction fetch: reads {pc,0} and {pc,1} from program ROM and issues one decoded instruction.
// Optional opcode trap controlled by FETCH_ILLEGAL_TRAP_EN (see fetch_decode).
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [ADDR_W-1:0]   pc,
    input  logic                prst,
    input  logic                brk,
    output logic [ADDR_W:0]     rom_addr,
    output logic                rom_en,
    input  logic [DATA_W-1:0]   rom_data,
    output logic [OP_W-1:0]     exe,
    output logic [REG_W-1:0]    ereg1,
    output logic [REG_W-1:0]    ereg2,
    output logic [EDATA_W-1:0]  edata,
    output logic                work,
    output logic                busy,
    output logic                illegal
);

    fetch_state_t state, next_state;

    logic [ADDR_W-1:0] pc_q;
    logic [OP_W-1:0]   dec_exe, exe_s;
    logic [REG_W-1:0]  dec_ereg1, dec_ereg2, ereg1_s, ereg2_s;
    logic              dec_illegal, ill_s, ill_q;

    fetch_decode u_decode (
        .hdr     (rom_data[EXE_HI:REG2_LO]),
        .exe     (dec_exe),
        .ereg1   (dec_ereg1),
        .ereg2   (dec_ereg2),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // A flush overrides every transition, including a fresh request in IDLE
    always_comb begin
        next_state = state;
        if (prst) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (req) next_state = W0;
                W0:      next_state = W1;
                W1:      next_state = brk ? HOLD : ISSUE;
                ISSUE:   next_state = IDLE;
                HOLD:    if (!brk) next_state = ISSUE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Address is a concatenation with the word select, so pc=all-ones reaches the top ROM words
    always_comb begin
        rom_en   = 1'b0;
        rom_addr = '0;
        work     = 1'b0;
        illegal  = 1'b0;
        busy     = (state != IDLE);
        if (!prst && !rst) begin
            case (state)
                IDLE: if (req) begin
                    rom_en   = 1'b1;
                    rom_addr = {pc, 1'b0};
                end
                W0: begin
                    rom_en   = 1'b1;
                    rom_addr = {pc_q, 1'b1};
                end
                ISSUE: begin
                    work    = 1'b1;
                    illegal = ill_q;
                end
                default: ;
            endcase
        end
    end

    // Word0 fields are staged so the visible outputs only change once the whole instruction is in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            exe_s   <= '0;
            ereg1_s <= '0;
            ereg2_s <= '0;
            ill_s   <= 1'b0;
            exe     <= '0;
            ereg1   <= '0;
            ereg2   <= '0;
            edata   <= '0;
            ill_q   <= 1'b0;
        end else if (!prst) begin
            if (state == IDLE && req)
                pc_q <= pc;
            if (state == W0) begin
                exe_s   <= dec_exe;
                ereg1_s <= dec_ereg1;
                ereg2_s <= dec_ereg2;
                ill_s   <= dec_illegal;
            end
            if (state == W1) begin
                exe   <= exe_s;
                ereg1 <= ereg1_s;
                ereg2 <= ereg2_s;
                edata <= rom_data[EDATA_W-1:0];
                ill_q <= ill_s;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a small registered program-ROM model.
// Illegal-opcode expectations follow FETCH_ILLEGAL_TRAP_EN.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst, req, prst, brk;
    logic [14:0] pc;
    logic [15:0] rom_addr;
    logic        rom_en;
    logic [15:0] rom_data;
    logic [4:0]  exe;
    logic [1:0]  ereg1, ereg2;
    logic [15:0] edata;
    logic        work, busy, illegal;

    int n_checks = 0;
    int n_fails  = 0;

    instr_fetch #(.ADDR_W(15), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .req(req), .pc(pc), .prst(prst), .brk(brk),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .exe(exe), .ereg1(ereg1), .ereg2(ereg2), .edata(edata),
        .work(work), .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        case (a)
            16'h000A: return 16'h2A80;
            16'h000B: return 16'h1234;
            16'h0020: return 16'hF580;
            16'h0021: return 16'h5555;
            16'h0040: return 16'h4A00;
            16'h0041: return 16'hCAFE;
            16'h0060: return 16'h0880;
            16'h0061: return 16'h7777;
            16'h0080: return 16'hFFFF;
            16'h0081: return 16'h9999;
            16'hFFFE: return 16'h1980;
            16'hFFFF: return 16'hBEEF;
            default:  return 16'h0000;
        endcase
    endfunction

    always @(posedge clk)
        if (rom_en) rom_data <= rom_word(rom_addr);

    task automatic step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        step();
        req = 1'b1; pc = 15'h0005;
        #1;
        n_checks++;
        if ({rom_en, rom_addr, work, busy, illegal} !== 20'h0) begin
            n_fails++;
            $display("[TB] FAIL reset_ctrl got en=%0b addr=%h work=%0b busy=%0b ill=%0b required all 0",
                     rom_en, rom_addr, work, busy, illegal);
        end
        n_checks++;
        if ({exe, ereg1, ereg2, edata} !== 25'h0) begin
            n_fails++;
            $display("[TB] FAIL reset_data got exe=%0d r1=%0d r2=%0d edata=%h required 0", exe, ereg1, ereg2, edata);
        end
        step();
        rst = 1'b0; req = 1'b0;
    endtask

    task automatic test_fetch;
        step();
        req = 1'b1; pc = 15'h0005;
        #1;
        n_checks++;
        if (rom_en !== 1'b1 || rom_addr !== 16'h000A || busy !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL fetch_w0addr got en=%0b addr=%h busy=%0b required 1/000a/0", rom_en, rom_addr, busy);
        end
        step();
        req = 1'b0; pc = 15'h0000;
        #1;
        n_checks++;
        if (rom_en !== 1'b1 || rom_addr !== 16'h000B || busy !== 1'b1 || work !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL fetch_w1addr got en=%0b addr=%h busy=%0b work=%0b required 1/000b/1/0",
                     rom_en, rom_addr, busy, work);
        end
        step();
        #1;
        n_checks++;
        if (rom_en !== 1'b0 || work !== 1'b0 || busy !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL fetch_w1 got en=%0b work=%0b busy=%0b required 0/0/1", rom_en, work, busy);
        end
        step();
        #1;
        n_checks++;
        if (work !== 1'b1 || exe !== 5'd5 || ereg1 !== 2'd1 || ereg2 !== 2'd1 || edata !== 16'h1234) begin
            n_fails++;
            $display("[TB] FAIL fetch_issue got work=%0b exe=%0d r1=%0d r2=%0d edata=%h required 1/5/1/1/1234",
                     work, exe, ereg1, ereg2, edata);
        end
        step();
        #1;
        n_checks++;
        if (work !== 1'b0 || busy !== 1'b0 || exe !== 5'd5 || edata !== 16'h1234) begin
            n_fails++;
            $display("[TB] FAIL fetch_hold got work=%0b busy=%0b exe=%0d edata=%h required 0/0/5/1234",
                     work, busy, exe, edata);
        end
    endtask

    task automatic test_back_to_back;
        logic exp_work;
        step();
        req = 1'b1; pc = 15'h0005;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            #1;
            exp_work = (k == 3 || k == 7);
            n_checks++;
            if (work !== exp_work) begin
                n_fails++;
                $display("[TB] FAIL b2b_work[%0d] got %0b required %0b", k, work, exp_work);
            end
        end
        step();
        req = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || work !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL b2b_idle got busy=%0b work=%0b required 0/0", busy, work);
        end
    endtask

    task automatic test_stall;
        step();
        req = 1'b1; pc = 15'h0020;
        step();
        req = 1'b0;
        step();
        brk = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            n_checks++;
            if (work !== 1'b0 || busy !== 1'b1 || exe !== 5'd9 || ereg1 !== 2'd1 || edata !== 16'hCAFE) begin
                n_fails++;
                $display("[TB] FAIL stall_hold[%0d] got work=%0b busy=%0b exe=%0d r1=%0d edata=%h required 0/1/9/1/cafe",
                         k, work, busy, exe, ereg1, edata);
            end
        end
        step();
        brk = 1'b0;
        #1;
        n_checks++;
        if (work !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL stall_release got work=%0b required 0", work);
        end
        step();
        #1;
        n_checks++;
        if (work !== 1'b1 || exe !== 5'd9 || ereg1 !== 2'd1 || ereg2 !== 2'd0 || edata !== 16'hCAFE) begin
            n_fails++;
            $display("[TB] FAIL stall_issue got work=%0b exe=%0d r1=%0d r2=%0d edata=%h required 1/9/1/0/cafe",
                     work, exe, ereg1, ereg2, edata);
        end
        step();
        #1;
        n_checks++;
        if (work !== 1'b0 || busy !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL stall_done got work=%0b busy=%0b required 0/0", work, busy);
        end
    endtask

    task automatic test_flush;
        step();
        req = 1'b1; pc = 15'h0040;
        step();
        prst = 1'b1;
        #1;
        n_checks++;
        if (rom_en !== 1'b0 || work !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL flush_w0 got en=%0b work=%0b required 0/0", rom_en, work);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            prst = 1'b0; req = 1'b0;
            #1;
            n_checks++;
            if (work !== 1'b0 || busy !== 1'b0 || exe !== 5'd9 || edata !== 16'hCAFE) begin
                n_fails++;
                $display("[TB] FAIL flush_idle[%0d] got work=%0b busy=%0b exe=%0d edata=%h required 0/0/9/cafe",
                         k, work, busy, exe, edata);
            end
        end
        step();
        prst = 1'b1; req = 1'b1; pc = 15'h0040;
        #1;
        n_checks++;
        if (rom_en !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL flush_idle_req got en=%0b required 0", rom_en);
        end
        step();
        prst = 1'b0; req = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL flush_wins got busy=%0b required 0", busy);
        end
    endtask

    task automatic test_wrap;
        step();
        req = 1'b1; pc = 15'h7FFF;
        #1;
        n_checks++;
        if (rom_addr !== 16'hFFFE || rom_en !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL wrap_addr0 got addr=%h en=%0b required fffe/1", rom_addr, rom_en);
        end
        step();
        req = 1'b0;
        #1;
        n_checks++;
        if (rom_addr !== 16'hFFFF || rom_en !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL wrap_addr1 got addr=%h en=%0b required ffff/1", rom_addr, rom_en);
        end
        step();
        step();
        #1;
        n_checks++;
        if (work !== 1'b1 || exe !== 5'd3 || ereg1 !== 2'd0 || ereg2 !== 2'd3 || edata !== 16'hBEEF) begin
            n_fails++;
            $display("[TB] FAIL wrap_issue got work=%0b exe=%0d r1=%0d r2=%0d edata=%h required 1/3/0/3/beef",
                     work, exe, ereg1, ereg2, edata);
        end
    endtask

    task automatic test_illegal;
        logic [4:0] exp_exe;
        logic       exp_ill;
`ifdef FETCH_ILLEGAL_TRAP_EN
        exp_exe = 5'd0;  exp_ill = 1'b1;
`else
        exp_exe = 5'd30; exp_ill = 1'b0;
`endif
        step();
        req = 1'b1; pc = 15'h0010;
        step();
        req = 1'b0;
        step();
        step();
        #1;
        n_checks++;
        if (work !== 1'b1 || exe !== exp_exe || illegal !== exp_ill || ereg1 !== 2'd2 || ereg2 !== 2'd3
            || edata !== 16'h5555) begin
            n_fails++;
            $display("[TB] FAIL illegal_issue got work=%0b exe=%0d ill=%0b r1=%0d r2=%0d edata=%h required 1/%0d/%0b/2/3/5555",
                     work, exe, illegal, ereg1, ereg2, edata, exp_exe, exp_ill);
        end
        step();
        #1;
        n_checks++;
        if (illegal !== 1'b0 || work !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL illegal_pulse got ill=%0b work=%0b required 0/0", illegal, work);
        end
    endtask

    task automatic test_reset_hold;
        step();
        req = 1'b1; pc = 15'h0030;
        step();
        req = 1'b0;
        step();
        brk = 1'b1;
        step();
        #1;
        n_checks++;
        if (busy !== 1'b1 || exe !== 5'd1 || ereg2 !== 2'd1 || edata !== 16'h7777) begin
            n_fails++;
            $display("[TB] FAIL rsthold_pre got busy=%0b exe=%0d r2=%0d edata=%h required 1/1/1/7777",
                     busy, exe, ereg2, edata);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({exe, ereg1, ereg2, edata, rom_addr, rom_en, work, busy, illegal} !== 45'h0) begin
            n_fails++;
            $display("[TB] FAIL rsthold_async got exe=%0d r1=%0d r2=%0d edata=%h addr=%h en=%0b work=%0b busy=%0b ill=%0b required all 0",
                     exe, ereg1, ereg2, edata, rom_addr, rom_en, work, busy, illegal);
        end
        step();
        rst = 1'b0; brk = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            n_checks++;
            if (work !== 1'b0 || busy !== 1'b0) begin
                n_fails++;
                $display("[TB] FAIL rsthold_after[%0d] got work=%0b busy=%0b required 0/0", k, work, busy);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; prst = 1'b0; brk = 1'b0; pc = '0;
        test_reset();
        test_fetch();
        test_back_to_back();
        test_stall();
        test_flush();
        test_wrap();
        test_illegal();
        test_reset_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning the program-counter width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning the program-ROM word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req, input, 1, core requests the instruction at pc.
REQ-006 SHALL have port pc, input, ADDR_W, the instruction index from the core counter.
REQ-007 SHALL have port prst, input, 1, program restart/flush.
REQ-008 SHALL have port brk, input, 1, core stall.
REQ-009 SHALL have port rom_addr, output, ADDR_W+1, the program-ROM word address {pc,sel}.
REQ-010 SHALL have port rom_en, output, 1, the ROM read strobe.
REQ-011 SHALL have port rom_data, input, DATA_W, ROM read data, valid one cycle after rom_en.
REQ-012 SHALL have ports exe (5), ereg1 (2), ereg2 (2) and edata (16), all outputs, the decoded instruction to the core.
REQ-013 SHALL have port work, output, 1, a one-cycle instruction-valid pulse.
REQ-014 SHALL have ports busy, output, 1 (fetch in progress) and illegal, output, 1 (bad-opcode pulse).

Function
REQ-015 SHALL store each instruction as two ROM words: word0 = {exe[15:11], ereg1[10:9], ereg2[8:7], reserved[6:0]}; word1 = edata.
REQ-016 SHALL implement the states IDLE, W0, W1, ISSUE and HOLD.
REQ-017 In IDLE with req=1, SHALL latch pc, drive rom_addr={pc,0} with rom_en=1, and go to W0.
REQ-018 In W0, SHALL drive rom_addr={pc_latched,1} with rom_en=1, capture the word0 fields at the end of the cycle, and go to W1.
REQ-019 In W1, SHALL capture rom_data into edata and go to ISSUE, or to HOLD if brk=1.
REQ-020 In ISSUE, SHALL assert work=1 for exactly one cycle and return to IDLE; req to work latency SHALL be 3 cycles.
REQ-021 In HOLD, SHALL keep all outputs stable with work=0, and go to ISSUE on the first cycle with brk=0.
REQ-022 SHALL keep busy=1 in every state except IDLE.
REQ-023 SHALL ignore req outside IDLE; a new fetch needs a fresh req in IDLE, so back-to-back throughput is one instruction per 4 cycles.
REQ-024 SHALL, when prst=1 in any state, go to IDLE next cycle, with work=0 and rom_en=0 and the in-flight ROM data discarded; prst SHALL win over a simultaneous req.
REQ-025 SHALL hold exe/ereg/edata at their last issued values between instructions.
REQ-026 SHALL form pc+sel by concatenation only, never by addition, so pc=all-ones does not wrap.

Reset
REQ-027 On rst, SHALL asynchronously force state=IDLE, and drive exe, ereg1, ereg2, edata, rom_addr, rom_en, work, busy and illegal to 0.
REQ-028 A reset asserted mid-fetch SHALL abort the fetch with no work pulse after release.

Configuration
REQ-029 With FETCH_ILLEGAL_TRAP_EN defined, SHALL treat opcodes 28-31 as illegal: exe=0 (NOP), with illegal pulsed in the ISSUE cycle alongside work.
REQ-030 Without FETCH_ILLEGAL_TRAP_EN, SHALL pass the opcode through unchanged and tie illegal to 0.

Structure
REQ-031 The package fetch_pkg SHALL hold the state enum, the word0 field bit positions, the opcode width, and ILLEGAL_OP_MIN=28.
REQ-032 The field split and illegal check SHALL live in one combinational sub-module, fetch_decode; the state machine and registers stay in instr_fetch.

Verification
REQ-033 Fetch case: with pc=0x0005, word0=0x2A80 and word1=0x1234, req SHALL produce work exactly 3 cycles later with exe=5, ereg1=1, ereg2=1, edata=0x1234.
REQ-034 Stall case: brk=1 during W1 for 4 cycles SHALL keep work=0 throughout and produce work the cycle after brk falls, with the outputs unchanged.
REQ-035 Flush case: prst in W0 SHALL produce no work pulse and return to IDLE with busy=0; a req in the same cycle SHALL be ignored.
REQ-036 Wrap case: pc=0x7FFF SHALL produce rom_addr sequence 0xFFFE then 0xFFFF.
REQ-037 Illegal case: word0 opcode 30 with FETCH_ILLEGAL_TRAP_EN SHALL give exe=0 and illegal=1 with work; without the macro, exe=30 and illegal=0.
REQ-038 Reset case: rst asserted during HOLD SHALL drive all outputs to 0 immediately, with no work pulse after release.
